// File: rtl/dualrail_nibble_tx_if.sv
// Link-side bundle for the dual-rail nibble transmitter: parallel request side,
// 3-wire line side and the FSM state for observation.
interface dualrail_nibble_tx_if #(
   parameter int NBITS = 4
);
   logic [NBITS-1:0] data;
   logic             send;
   logic             busy;
   logic             done;
   logic             start;
   logic             bin1;
   logic             bin0;
   logic [2:0]       fsm_state;

   // send is a request, not a valid/ready pair: it is taken on any clk edge
   // where send=1 and busy=0; while busy=1 it is ignored (no queuing).
   modport master (
      output data, send,
      input  busy, done, start, bin1, bin0, fsm_state
   );

   modport slave (
      input  data, send,
      output busy, done, start, bin1, bin0, fsm_state
   );
endinterface

// File: rtl/dualrail_nibble_tx.sv
// Transmit end of the start/dual-rail serial link: a start-low preamble, then
// MSB-first dual-rail symbols each followed by an 11 spacer, then an idle gap.
module dualrail_nibble_tx #(
   parameter int NBITS        = 4,
   parameter int START_CYCLES = 3,
   parameter int GAP_CYCLES   = 1
) (
   input logic                clk,
   input logic                rst,
   dualrail_nibble_tx_if.slave link
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      SPACE = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam int CMAX = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int BW   = $clog2(NBITS + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic             start_q, start_d;
   logic             bin1_q, bin1_d;
   logic             bin0_q, bin0_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         start_q   <= 1'b1;
         bin1_q    <= 1'b1;
         bin0_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         start_q   <= start_d;
         bin1_q    <= bin1_d;
         bin0_q    <= bin0_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Lines default to the 11 spacer/idle code; only the symbol transitions
   // override them, so 00 can never be produced.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      start_d   = start_q;
      bin1_d    = 1'b1;
      bin0_d    = 1'b1;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            start_d = 1'b1;
            if (link.send) begin
               shreg_d   = link.data;
               busy_d    = 1'b1;
               start_d   = 1'b0;
               cnt_d     = CW'(START_CYCLES - 1);
               bit_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               start_d = 1'b1;
               bin1_d  = ~shreg_q[NBITS-1];
               bin0_d  = shreg_q[NBITS-1];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DATA: begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            state_d   = SPACE;
         end
         SPACE: begin
            if (bit_cnt_q < BW'(NBITS)) begin
               bin1_d  = ~shreg_q[NBITS-1];
               bin0_d  = shreg_q[NBITS-1];
               state_d = DATA;
            end else begin
               cnt_d   = CW'(GAP_CYCLES - 1);
               done_d  = (GAP_CYCLES == 1);
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d  = cnt_q - CW'(1);
               done_d = (cnt_q == CW'(1));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign link.start     = start_q;
   assign link.bin1      = bin1_q;
   assign link.bin0      = bin0_q;
   assign link.busy      = busy_q;
   assign link.done      = done_q;
   assign link.fsm_state = state_q;

endmodule

// File: tb/tb_dualrail_nibble_tx.sv
// Bench for dualrail_nibble_tx: per-cycle frame model plus a loopback line
// decoder that scores received words against the words sent.
module tb_dualrail_nibble_tx;

   localparam int N = 4;
   localparam int S = 3;
   localparam int G = 1;
   localparam int L = S + 2 * N + G;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   logic [N-1:0] exp_q[$];

   dualrail_nibble_tx_if #(.NBITS(N)) link();

   dualrail_nibble_tx #(
      .NBITS(N),
      .START_CYCLES(S),
      .GAP_CYCLES(G)
   ) dut (
      .clk(clk),
      .rst(rst),
      .link(link.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed={start,bin1,bin0,busy,done}=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Expected {start,bin1,bin0,busy,done} k clocks after the accept edge.
   function automatic logic [4:0] exp_vec(input logic [N-1:0] word, input int k);
      logic b;
      if (k < S) return 5'b0_11_10;
      if (k < S + 2 * N) begin
         if (((k - S) % 2) == 1) return 5'b1_11_10;
         b = word[N - 1 - (k - S) / 2];
         return b ? 5'b1_01_10 : 5'b1_10_10;
      end
      if (k < L) return {4'b1_11_1, (k == L - 1)};
      return 5'b1_11_00;
   endfunction

   // Loopback receiver model and line-rule monitor.
   int          mon_syms;
   logic [N-1:0] mon_word;
   bit          mon_prev_data;
   logic [N-1:0] mon_exp;

   always @(negedge clk) begin
      if (rst) begin
         mon_syms      = 0;
         mon_word      = '0;
         mon_prev_data = 0;
      end else begin
         n_assert++;
         assert ({link.bin1, link.bin0} !== 2'b00) else begin
            n_fail++;
            $error("FAIL line_00 observed=%b%b expected=not 00", link.bin1, link.bin0);
         end
         if (mon_prev_data) begin
            n_assert++;
            assert ({link.bin1, link.bin0} === 2'b11) else begin
               n_fail++;
               $error("FAIL spacer_after_symbol observed=%b%b expected=11", link.bin1, link.bin0);
            end
         end
         if (link.start === 1'b0) begin
            mon_syms = 0;
            mon_word = '0;
         end
         mon_prev_data = 0;
         if ({link.bin1, link.bin0} === 2'b01 || {link.bin1, link.bin0} === 2'b10) begin
            mon_syms++;
            mon_word      = {mon_word[N-2:0], link.bin0};
            mon_prev_data = 1;
         end
         if (link.done === 1'b1) begin
            mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_assert++;
            assert (mon_syms == N) else begin
               n_fail++;
               $error("FAIL symbol_count observed=%0d expected=%0d", mon_syms, N);
            end
            n_assert++;
            assert (mon_word === mon_exp) else begin
               n_fail++;
               $error("FAIL rx_word observed=%h expected=%h", mon_word, mon_exp);
            end
         end
      end
   end

   task automatic run_frame(input logic [N-1:0] word, input int pulse_k,
                            input logic [N-1:0] alt, input bit hold);
      link.data = word;
      link.send = 1'b1;
      exp_q.push_back(word);
      for (int k = 0; k <= L; k++) begin
         @(posedge clk);
         #1;
         if (k == 0 || k == pulse_k) begin
            if (!hold) link.send = 1'b0;
            link.data = N'($urandom);
         end
         @(negedge clk);
         check($sformatf("frame_%h_k%0d", word, k),
               {link.start, link.bin1, link.bin0, link.busy, link.done}, exp_vec(word, k));
         if (k + 1 == pulse_k) begin
            link.send = 1'b1;
            link.data = alt;
         end
      end
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      link.data = '0;
      link.send = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      #2;
      check("reset", {link.start, link.bin1, link.bin0, link.busy, link.done}, 5'b1_11_00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", {link.start, link.bin1, link.bin0, link.busy, link.done}, 5'b1_11_00);

      // Directed words
      run_frame(4'b1011, -1, '0, 1'b0);
      run_frame(4'b0000, -1, '0, 1'b0);
      run_frame(4'b1111, -1, '0, 1'b0);

      // send pulsed mid-frame must be ignored
      run_frame(4'b1001, 4, 4'b0110, 1'b0);
      @(negedge clk);
      check("no_accept_after_ignored", {link.start, link.bin1, link.bin0, link.busy, link.done}, 5'b1_11_00);

      // Random words
      for (int i = 0; i < 4; i++) run_frame(N'($urandom_range(0, 15)), -1, '0, 1'b0);

      // send held high: back-to-back frames every L+1 clocks
      run_frame(4'h5, -1, '0, 1'b1);
      run_frame(4'hA, -1, '0, 1'b1);
      run_frame(4'h5, -1, '0, 1'b1);
      run_frame(4'hA, -1, '0, 1'b0);
      @(negedge clk);

      // Reset mid-frame at T0+6
      link.data = N'($urandom);
      link.send = 1'b1;
      exp_q.push_back(link.data);
      @(posedge clk);
      #1 link.send = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_frame", {link.start, link.bin1, link.bin0, link.busy, link.done}, 5'b1_11_00);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("rst_held", {link.start, link.bin1, link.bin0, link.busy, link.done}, 5'b1_11_00);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_mid_reset", {link.start, link.bin1, link.bin0, link.busy, link.done}, 5'b1_11_00);
      run_frame(N'($urandom_range(0, 15)), -1, '0, 1'b0);

      repeat (3) @(negedge clk);
      n_assert++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL pending_words observed=%0d expected=0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
